// File: rtl/mem_arbiter_ctrl.sv
// Two-port arbiter around a 16x8 unified memory; serialises READ, WRITE and
// in-memory read-modify-write (DOUBLE, INVERT) with one transaction in flight.
module mem_arbiter_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int LOADER_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              c_req_i,
    input  logic [1:0]        c_op_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_ack_o,
    output logic [DATA_W-1:0] c_rdata_o,
    input  logic              l_req_i,
    input  logic [1:0]        l_op_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic              l_ack_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              busy_o,
    output logic              owner_o
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration happens here
    // ACCESS | memory read, or the WRITE itself
    // MODIFY | write back doubled / inverted word (RMW only)
    // RESP   | one-cycle ack to the owner, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MODIFY, S_RESP} state_t;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_DOUBLE = 2'b10;
    localparam logic       PRIO_L    = (LOADER_PRIO != 0);
    localparam int         DEPTH     = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic [DATA_W-1:0]   c_rdata_q, l_rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic                grant_l;

    // On a tie the loader wins under fixed priority, otherwise whoever was not served last.
    assign grant_l = l_req_i && (!c_req_i || PRIO_L || !last_owner_q);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_we       = 1'b0;
        mem_wdata    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (c_req_i || l_req_i) begin
                    owner_d = grant_l;
                    op_d    = grant_l ? l_op_i    : c_op_i;
                    addr_d  = grant_l ? l_addr_i  : c_addr_i;
                    wdata_d = grant_l ? l_wdata_i : c_wdata_i;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (op_q == OP_WRITE) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    rd_d      = wdata_q;
                    state_d   = S_RESP;
                end else begin
                    rd_d    = mem_q[addr_q];
                    state_d = (op_q == OP_READ) ? S_RESP : S_MODIFY;
                end
            end
            S_MODIFY: begin
                mem_we    = 1'b1;
                mem_wdata = (op_q == OP_DOUBLE) ? {rd_q[DATA_W-2:0], 1'b0} : ~rd_q;
                rd_d      = mem_wdata;
                state_d   = S_RESP;
            end
            S_RESP: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            c_rdata_q    <= '0;
            l_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            if (state_d == S_RESP && state_q != S_RESP) begin
                if (owner_q) l_rdata_q <= rd_d;
                else         c_rdata_q <= rd_d;
            end
        end
    end

    // Memory is deliberately not reset; writes are gated by the reset state.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[addr_q] <= mem_wdata;
    end

    assign c_ack_o   = (state_q == S_RESP) && !owner_q;
    assign l_ack_o   = (state_q == S_RESP) &&  owner_q;
    assign c_rdata_o = c_rdata_q;
    assign l_rdata_o = l_rdata_q;
    assign busy_o    = (state_q != S_IDLE);
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: one round-robin and one loader-priority
// instance driven by shared inputs.
module tb_mem_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_req = 1'b0, l_req = 1'b0;
    logic [1:0] c_op = 2'b00, l_op = 2'b00;
    logic [3:0] c_addr = 4'd0, l_addr = 4'd0;
    logic [7:0] c_wdata = 8'd0, l_wdata = 8'd0;

    logic       a_c_ack, a_l_ack, a_busy, a_owner;
    logic [7:0] a_c_rdata, a_l_rdata;
    logic       b_c_ack, b_l_ack, b_busy, b_owner;
    logic [7:0] b_c_rdata, b_l_rdata;

    int vec = 0;
    int errs = 0;
    int ca_cnt = 0, la_cnt = 0, wide_a = 0;
    logic prev_ca = 1'b0, prev_la = 1'b0;
    bit grant_a[$];
    bit grant_b[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.DATA_W(8), .ADDR_W(4), .LOADER_PRIO(0)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .c_req_i(c_req), .c_op_i(c_op), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_ack_o(a_c_ack), .c_rdata_o(a_c_rdata),
        .l_req_i(l_req), .l_op_i(l_op), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_ack_o(a_l_ack), .l_rdata_o(a_l_rdata),
        .busy_o(a_busy), .owner_o(a_owner)
    );

    mem_arbiter_ctrl #(.DATA_W(8), .ADDR_W(4), .LOADER_PRIO(1)) u_dut_prio (
        .clk_i(clk), .rst_n_i(rst_n),
        .c_req_i(c_req), .c_op_i(c_op), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_ack_o(b_c_ack), .c_rdata_o(b_c_rdata),
        .l_req_i(l_req), .l_op_i(l_op), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_ack_o(b_l_ack), .l_rdata_o(b_l_rdata),
        .busy_o(b_busy), .owner_o(b_owner)
    );

    always @(negedge clk) begin
        if (a_c_ack) begin ca_cnt++; grant_a.push_back(1'b0); end
        if (a_l_ack) begin la_cnt++; grant_a.push_back(1'b1); end
        if ((a_c_ack && prev_ca) || (a_l_ack && prev_la)) wide_a++;
        prev_ca = a_c_ack;
        prev_la = a_l_ack;
        if (b_c_ack) grant_b.push_back(1'b0);
        if (b_l_ack) grant_b.push_back(1'b1);
    end

    // Runs one transaction on u_dut; lat = edges from sampling edge to ack, -1 on timeout.
    task automatic do_txn(input bit port, input logic [1:0] op, input logic [3:0] addr,
                          input logic [7:0] wd, output int lat, output logic [7:0] rdata);
        int n = 0;
        lat = -1;
        rdata = 8'h00;
        @(posedge clk); #1;
        if (port) begin l_req = 1'b1; l_op = op; l_addr = addr; l_wdata = wd; end
        else      begin c_req = 1'b1; c_op = op; c_addr = addr; c_wdata = wd; end
        while (n < 10) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (port ? a_l_ack : a_c_ack) begin
                lat = n;
                rdata = port ? a_l_rdata : a_c_rdata;
                break;
            end
        end
        c_req = 1'b0;
        l_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        vec++; if (a_owner !== 1'b0) begin errs++; $display("FAIL reset_owner got=%b exp=0", a_owner); end
        vec++; if ({a_c_ack, a_l_ack} !== 2'b00) begin errs++; $display("FAIL reset_ack got=%b exp=00", {a_c_ack, a_l_ack}); end
        vec++; if ({a_c_rdata, a_l_rdata} !== 16'h0000) begin errs++; $display("FAIL reset_rdata got=%h exp=0000", {a_c_rdata, a_l_rdata}); end
        vec++; if (b_busy !== 1'b0) begin errs++; $display("FAIL reset_busy_prio got=%b exp=0", b_busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loader_rw;
        int lat; logic [7:0] rd; int ca0;
        logic [7:0] exp;
        ca0 = ca_cnt;
        do_txn(1'b1, 2'b01, 4'd5, 8'h3C, lat, rd);
        vec++; if (lat !== 2) begin errs++; $display("FAIL l_write_lat got=%0d exp=2", lat); end
        exp_q.push_back(8'h3C);
        do_txn(1'b1, 2'b00, 4'd5, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (lat !== 2) begin errs++; $display("FAIL l_read_lat got=%0d exp=2", lat); end
        vec++; if (rd !== exp) begin errs++; $display("FAIL l_read_data got=%h exp=%h", rd, exp); end
        vec++; if (ca_cnt !== ca0) begin errs++; $display("FAIL l_no_cack got=%0d exp=%0d", ca_cnt, ca0); end
        vec++; if (a_c_rdata !== 8'h00) begin errs++; $display("FAIL l_crdata_held got=%h exp=00", a_c_rdata); end
    endtask

    task automatic test_rmw;
        int lat; logic [7:0] rd;
        logic [7:0] exp;
        do_txn(1'b0, 2'b01, 4'd2, 8'h81, lat, rd);
        vec++; if (rd !== 8'h81) begin errs++; $display("FAIL c_write_rdata got=%h exp=81", rd); end
        exp_q.push_back(8'h02);
        do_txn(1'b0, 2'b10, 4'd2, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (lat !== 3) begin errs++; $display("FAIL double_lat got=%0d exp=3", lat); end
        vec++; if (rd !== exp) begin errs++; $display("FAIL double_data got=%h exp=%h", rd, exp); end
        exp_q.push_back(8'h02);
        do_txn(1'b0, 2'b00, 4'd2, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (rd !== exp) begin errs++; $display("FAIL double_mem got=%h exp=%h", rd, exp); end
        exp_q.push_back(8'hFD);
        do_txn(1'b0, 2'b11, 4'd2, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (lat !== 3) begin errs++; $display("FAIL invert_lat got=%0d exp=3", lat); end
        vec++; if (rd !== exp) begin errs++; $display("FAIL invert_data got=%h exp=%h", rd, exp); end
        exp_q.push_back(8'hFD);
        do_txn(1'b1, 2'b00, 4'd2, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (rd !== exp) begin errs++; $display("FAIL invert_mem got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_arbitration;
        int n;
        bit seen_c;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_a.delete();
        grant_b.delete();
        wide_a = 0;
        @(posedge clk); #1;
        c_req = 1'b1; c_op = 2'b00; c_addr = 4'd5;
        l_req = 1'b1; l_op = 2'b00; l_addr = 4'd2;
        n = 0;
        while (n < 40 && (grant_a.size() < 4 || grant_b.size() < 4)) begin
            @(negedge clk); n++;
        end
        vec++; if (grant_a.size() < 4) begin errs++; $display("FAIL rr_grants got=%0d exp>=4", grant_a.size()); end
        else begin
            vec++; if ({grant_a[0], grant_a[1], grant_a[2], grant_a[3]} !== 4'b0101)
                begin errs++; $display("FAIL rr_order got=%b exp=0101", {grant_a[0], grant_a[1], grant_a[2], grant_a[3]}); end
        end
        vec++; if (wide_a !== 0) begin errs++; $display("FAIL rr_ack_width got=%0d exp=0", wide_a); end
        vec++; if (a_c_rdata !== 8'h3C) begin errs++; $display("FAIL rr_c_rdata got=%h exp=3c", a_c_rdata); end
        vec++; if (a_l_rdata !== 8'hFD) begin errs++; $display("FAIL rr_l_rdata got=%h exp=fd", a_l_rdata); end
        vec++; if (grant_b.size() < 4) begin errs++; $display("FAIL prio_grants got=%0d exp>=4", grant_b.size()); end
        else begin
            vec++; if ({grant_b[0], grant_b[1], grant_b[2], grant_b[3]} !== 4'b1111)
                begin errs++; $display("FAIL prio_order got=%b exp=1111", {grant_b[0], grant_b[1], grant_b[2], grant_b[3]}); end
        end
        l_req = 1'b0;
        seen_c = 1'b0;
        n = 0;
        while (n < 20 && !seen_c) begin
            @(negedge clk); n++;
            if (b_c_ack) seen_c = 1'b1;
        end
        vec++; if (seen_c !== 1'b1) begin errs++; $display("FAIL prio_cpu_after_drop got=%b exp=1", seen_c); end
        c_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [7:0] rd; int ca0;
        logic [7:0] exp;
        do_txn(1'b0, 2'b01, 4'd7, 8'h11, lat, rd);
        ca0 = ca_cnt;
        c_req = 1'b1; c_op = 2'b01; c_addr = 4'd7; c_wdata = 8'hAA;
        @(posedge clk); #2;
        vec++; if (a_busy !== 1'b1) begin errs++; $display("FAIL mid_busy_access got=%b exp=1", a_busy); end
        rst_n = 1'b0;
        #1;
        vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL mid_busy got=%b exp=0", a_busy); end
        vec++; if (a_c_rdata !== 8'h00) begin errs++; $display("FAIL mid_rdata got=%h exp=00", a_c_rdata); end
        c_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (ca_cnt !== ca0) begin errs++; $display("FAIL mid_no_ack got=%0d exp=%0d", ca_cnt, ca0); end
        exp_q.push_back(8'h11);
        do_txn(1'b0, 2'b00, 4'd7, 8'h00, lat, rd);
        exp = exp_q.pop_front();
        vec++; if (rd !== exp) begin errs++; $display("FAIL mid_mem_kept got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_req_drop;
        int lat; logic [7:0] rd; int ca0; int n;
        logic [7:0] exp;
        do_txn(1'b0, 2'b01, 4'd0, 8'h5A, lat, rd);
        ca0 = ca_cnt;
        exp_q.push_back(8'h5A);
        c_req = 1'b1; c_op = 2'b00; c_addr = 4'd0;
        @(posedge clk); #1;
        c_req = 1'b0;
        lat = -1; n = 1;
        while (n < 10 && lat < 0) begin
            @(negedge clk);
            if (a_c_ack) lat = n;
            else begin @(posedge clk); n++; end
        end
        exp = exp_q.pop_front();
        vec++; if (lat !== 2) begin errs++; $display("FAIL drop_lat got=%0d exp=2", lat); end
        vec++; if (a_c_rdata !== exp) begin errs++; $display("FAIL drop_data got=%h exp=%h", a_c_rdata, exp); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        vec++; if (ca_cnt !== ca0 + 1) begin errs++; $display("FAIL drop_single got=%0d exp=%0d", ca_cnt, ca0 + 1); end
        vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL drop_idle got=%b exp=0", a_busy); end
    endtask

    initial begin
        test_reset();
        test_loader_rw();
        test_rmw();
        test_arbitration();
        test_reset_mid();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
